axi_arbiter_r_wrr: RTL and testbench

Read-channel arbiter for the shared AXI interconnect. Shares one slave-side AR/R path among four masters using weighted round-robin. A grant is held from AR handshake through the RLAST beat. Per-master burst credits (run-time configurable) set how many consecutive bursts a master may issue before rotation. Grant outputs drive the AR/R muxes in the interconnect.

---
 rtl/axi_arbiter_r_wrr.sv | 231 +++++++++++++++++++++++
 tb/tb_axi_arbiter_r_wrr.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_arbiter_r_wrr.sv
// -----------------------------------------------------------------------------
// axi_arbiter_r_wrr
//
// Weighted round-robin arbiter for the shared AXI read path (AR + R) between
// four masters. A grant is held from the AR handshake through the RLAST beat.
// Each master gets a credit of max(weight,1) bursts, then the grant rotates to
// the next requester.
//
// Optional feature: define AXI_ARB_R_TIMEOUT_EN to enable the R-phase stall
// timeout (sticky timeout_err, forced rotation). Without it, timeout_err is
// tied low and err_clr is ignored.
//
// Ports:
//   ACLK, ARESETn          clock, asynchronous active-low reset
//   mN_ARVALID, mN_RREADY  per-master AR request and R ready (N = 0..3)
//   m_ARREADY, m_RVALID,   slave-side handshake signals of the shared path
//   m_RLAST
//   cfg_weight             weight of master i in [i*CW +: CW], 0 acts as 1
//   err_clr                clears timeout_err
//   mN_rgrnt               registered one-hot grant
//   grnt_id                index of the granted master
//   busy                   high while in the R phase
//   r_beats                beats completed in the current burst (saturating)
//   timeout_err            sticky R-phase stall error
// -----------------------------------------------------------------------------
module axi_arbiter_r_wrr #(
   parameter int unsigned CW          = 4,
   parameter int unsigned BEAT_W      = 8,
   parameter int unsigned TIMEOUT_CYC = 256
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic              m0_ARVALID,
   input  logic              m1_ARVALID,
   input  logic              m2_ARVALID,
   input  logic              m3_ARVALID,
   input  logic              m0_RREADY,
   input  logic              m1_RREADY,
   input  logic              m2_RREADY,
   input  logic              m3_RREADY,
   input  logic              m_ARREADY,
   input  logic              m_RVALID,
   input  logic              m_RLAST,
   input  logic [4*CW-1:0]   cfg_weight,
   input  logic              err_clr,
   output logic              m0_rgrnt,
   output logic              m1_rgrnt,
   output logic              m2_rgrnt,
   output logic              m3_rgrnt,
   output logic [1:0]        grnt_id,
   output logic              busy,
   output logic [BEAT_W-1:0] r_beats,
   output logic              timeout_err
);

   typedef enum logic [1:0] {
      StAr = 2'd0,
      StR  = 2'd1
   } state_e;

   state_e            state_q, state_d;
   logic [1:0]        owner_q, owner_d;
   logic [CW-1:0]     credit_q, credit_d;
   logic [BEAT_W-1:0] beats_q, beats_d;
   logic [3:0]        grant_q;
   logic [1:0]        gid_q;
   logic              busy_q;

   logic [3:0]        arvalid;
   logic [3:0]        rready;
   logic              beat;
   logic              grant_aligned;
   logic [1:0]        cand1, cand2, cand3;
   logic [1:0]        nxt_idx;
   logic [CW-1:0]     cred_dec;

   assign arvalid = {m3_ARVALID, m2_ARVALID, m1_ARVALID, m0_ARVALID};
   assign rready  = {m3_RREADY, m2_RREADY, m1_RREADY, m0_RREADY};
   assign beat    = m_RVALID & rready[owner_q];
   assign cred_dec = credit_q - 1'b1;

   // The grant lags owner by one cycle. An AR handshake only counts once the
   // interconnect mux actually points at the owner.
   assign grant_aligned = (gid_q == owner_q);

   function automatic logic [CW-1:0] load_val(input logic [1:0]      idx,
                                              input logic [4*CW-1:0] w);
      logic [CW-1:0] v;
      v = w[idx*CW +: CW];
      return (v == '0) ? {{(CW-1){1'b0}}, 1'b1} : v;
   endfunction

   // Nearest requester after the owner; falls back to owner+1 when none.
   always_comb begin
      cand1   = owner_q + 2'd1;
      cand2   = owner_q + 2'd2;
      cand3   = owner_q + 2'd3;
      nxt_idx = cand1;
      if (arvalid[cand1]) begin
         nxt_idx = cand1;
      end else if (arvalid[cand2]) begin
         nxt_idx = cand2;
      end else if (arvalid[cand3]) begin
         nxt_idx = cand3;
      end
   end

`ifdef AXI_ARB_R_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYC - 1);

   logic [TW-1:0] tmo_q, tmo_d;
   logic          err_q, err_d;
   logic          tmo_fire;
`else
   logic        unused_err_clr;
   logic [31:0] unused_tmo_cyc;
   assign unused_err_clr = err_clr;
   assign unused_tmo_cyc = TIMEOUT_CYC;
`endif

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      credit_d = credit_q;
      beats_d  = beats_q;
`ifdef AXI_ARB_R_TIMEOUT_EN
      tmo_fire = 1'b0;
`endif
      case (state_q)
         StAr: begin
            // Credit of zero only occurs right after reset: load the owner's weight.
            if (credit_q == '0) begin
               credit_d = load_val(owner_q, cfg_weight);
            end
            if (arvalid[owner_q]) begin
               // Owner is never switched away while its ARVALID is high.
               if (m_ARREADY && grant_aligned) begin
                  state_d = StR;
                  beats_d = '0;
               end
            end else if (arvalid != 4'd0) begin
               owner_d  = nxt_idx;
               credit_d = load_val(nxt_idx, cfg_weight);
            end
         end
         StR: begin
            if (beat && (beats_q != {BEAT_W{1'b1}})) begin
               beats_d = beats_q + 1'b1;
            end
            if (beat && m_RLAST) begin
               state_d = StAr;
               if (cred_dec == '0) begin
                  owner_d  = nxt_idx;
                  credit_d = load_val(nxt_idx, cfg_weight);
               end else begin
                  credit_d = cred_dec;
               end
            end
`ifdef AXI_ARB_R_TIMEOUT_EN
            else if (!beat && (tmo_q == TmoLast)) begin
               tmo_fire = 1'b1;
               state_d  = StAr;
               owner_d  = nxt_idx;
               credit_d = load_val(nxt_idx, cfg_weight);
            end
`endif
         end
         default: begin
            state_d  = StAr;
            owner_d  = 2'd0;
            credit_d = '0;
            beats_d  = '0;
         end
      endcase
   end

`ifdef AXI_ARB_R_TIMEOUT_EN
   // Counter only runs inside the R phase and restarts on every beat.
   always_comb begin
      tmo_d = '0;
      if ((state_q == StR) && !beat && !tmo_fire) begin
         tmo_d = tmo_q + 1'b1;
      end
      // A new timeout wins over a simultaneous clear.
      err_d = tmo_fire ? 1'b1 : (err_clr ? 1'b0 : err_q);
   end
`endif

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q  <= StAr;
         owner_q  <= 2'd0;
         credit_q <= '0;
         beats_q  <= '0;
         grant_q  <= 4'b0001;
         gid_q    <= 2'd0;
         busy_q   <= 1'b0;
`ifdef AXI_ARB_R_TIMEOUT_EN
         tmo_q    <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         credit_q <= credit_d;
         beats_q  <= beats_d;
         grant_q  <= 4'b0001 << owner_q;
         gid_q    <= owner_q;
         busy_q   <= (state_d == StR);
`ifdef AXI_ARB_R_TIMEOUT_EN
         tmo_q    <= tmo_d;
         err_q    <= err_d;
`endif
      end
   end

   assign m0_rgrnt = grant_q[0];
   assign m1_rgrnt = grant_q[1];
   assign m2_rgrnt = grant_q[2];
   assign m3_rgrnt = grant_q[3];
   assign grnt_id  = gid_q;
   assign busy     = busy_q;
   assign r_beats  = beats_q;
`ifdef AXI_ARB_R_TIMEOUT_EN
   assign timeout_err = err_q;
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_arbiter_r_wrr.sv
// -----------------------------------------------------------------------------
// tb_axi_arbiter_r_wrr
//
// Directed bench for axi_arbiter_r_wrr. A small master/slave model drives the
// AR/R handshakes from the DUT grants; AR handshakes are logged by master index
// and compared against hand-computed orders. The slave drops ARREADY for the
// cycle right after each RLAST beat, while the registered grant catches up with
// a rotated owner.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_arbiter_r_wrr;

   localparam int unsigned CW          = 4;
   localparam int unsigned BEAT_W      = 8;
   localparam int unsigned TIMEOUT_CYC = 16;

   logic              ACLK;
   logic              ARESETn;
   logic [3:0]        arv;
   logic [3:0]        rr;
   logic              m_ARREADY;
   logic              m_RVALID;
   logic              m_RLAST;
   logic [4*CW-1:0]   cfg_weight;
   logic              err_clr;
   logic              m0_rgrnt, m1_rgrnt, m2_rgrnt, m3_rgrnt;
   logic [1:0]        grnt_id;
   logic              busy;
   logic [BEAT_W-1:0] r_beats;
   logic              timeout_err;
   logic [3:0]        gvec;

   assign gvec = {m3_rgrnt, m2_rgrnt, m1_rgrnt, m0_rgrnt};

   axi_arbiter_r_wrr #(
      .CW         (CW),
      .BEAT_W     (BEAT_W),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .ACLK       (ACLK),
      .ARESETn    (ARESETn),
      .m0_ARVALID (arv[0]),
      .m1_ARVALID (arv[1]),
      .m2_ARVALID (arv[2]),
      .m3_ARVALID (arv[3]),
      .m0_RREADY  (rr[0]),
      .m1_RREADY  (rr[1]),
      .m2_RREADY  (rr[2]),
      .m3_RREADY  (rr[3]),
      .m_ARREADY  (m_ARREADY),
      .m_RVALID   (m_RVALID),
      .m_RLAST    (m_RLAST),
      .cfg_weight (cfg_weight),
      .err_clr    (err_clr),
      .m0_rgrnt   (m0_rgrnt),
      .m1_rgrnt   (m1_rgrnt),
      .m2_rgrnt   (m2_rgrnt),
      .m3_rgrnt   (m3_rgrnt),
      .grnt_id    (grnt_id),
      .busy       (busy),
      .r_beats    (r_beats),
      .timeout_err(timeout_err)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   int checks;
   int errors;
   int req [4];
   int remain;
   int blen;
   bit ar_en;
   bit rv_en;
   int cyc;
   int lst_cyc;
   bit lst_flag;
   int ar_log [$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input bit after_last);
      for (int i = 0; i < 4; i++) arv[i] = (req[i] > 0);
      m_RVALID  = rv_en && (remain > 0);
      m_RLAST   = m_RVALID && (remain == 1);
      m_ARREADY = ar_en && !after_last;
   endtask

   // One clock: predict handshakes from the wires, advance, then update the model.
   task automatic step();
      bit hs;
      bit bt;
      int gid;
      gid = int'(grnt_id);
      hs  = !busy && m_ARREADY && ((arv & gvec) != 4'd0);
      bt  = busy && m_RVALID && rr[gid];
      lst_flag = bt && m_RLAST;
      if (lst_flag) lst_cyc = cyc;
      @(posedge ACLK);
      #1;
      cyc++;
      if (hs) begin
         ar_log.push_back(gid);
         req[gid]--;
         remain = blen;
      end
      if (bt) remain--;
      drive(lst_flag);
   endtask

   task automatic do_reset(input logic [15:0] w);
      ARESETn = 1'b0;
      for (int i = 0; i < 4; i++) req[i] = 0;
      remain     = 0;
      ar_en      = 1'b1;
      rv_en      = 1'b1;
      cfg_weight = w;
      err_clr    = 1'b0;
      rr         = 4'hf;
      ar_log.delete();
      drive(1'b0);
      repeat (2) @(posedge ACLK);
      #1;
      ARESETn = 1'b1;
      cyc = 0;
   endtask

   function automatic bit idle();
      return (req[0] == 0) && (req[1] == 0) && (req[2] == 0) && (req[3] == 0) &&
             (remain == 0) && !busy;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1);
   end

   initial begin
      int n;
      bit moved;
      int g_cyc;
      int first_lst;
      int exp3 [8];
      checks = 0;
      errors = 0;
      blen   = 1;
      exp3   = '{0, 0, 0, 2, 0, 0, 0, 2};

      // Reset state and parking on m0.
      do_reset(16'h1111);
      check_val("rst_grant", 32'(gvec), 32'h1);
      check_val("rst_gid", 32'(grnt_id), 32'h0);
      check_val("rst_busy", 32'(busy), 32'h0);
      check_val("rst_beats", 32'(r_beats), 32'h0);
      check_val("rst_err", 32'(timeout_err), 32'h0);
      moved = 1'b0;
      repeat (20) begin
         step();
         if ((gvec !== 4'b0001) || busy) moved = 1'b1;
      end
      check_val("park20", 32'(moved), 32'h0);

      // m1 and m3 request, weights 1, 4-beat bursts.
      do_reset(16'h1111);
      blen = 4;
      repeat (5) step();
      req[1] = 1;
      req[3] = 1;
      drive(1'b0);
      g_cyc = -1;
      first_lst = -1;
      n = 0;
      while (!idle() && (n < 200)) begin
         step();
         n++;
         if (lst_flag) begin
            check_val("t2_beats", 32'(r_beats), 32'd4);
            if (first_lst < 0) first_lst = lst_cyc;
         end
         if (m3_rgrnt && (g_cyc < 0)) g_cyc = cyc;
      end
      check_val("t2_drain", 32'(idle()), 32'h1);
      check_val("t2_count", 32'(ar_log.size()), 32'd2);
      if (ar_log.size() == 2) begin
         check_val("t2_first", 32'(ar_log[0]), 32'd1);
         check_val("t2_second", 32'(ar_log[1]), 32'd3);
      end
      check_val("t2_m3_gap", 32'(g_cyc - first_lst), 32'd2);

      // Weight 3 on m0 against weight 1 on m2, 2-beat bursts.
      do_reset(16'h1113);
      blen   = 2;
      req[0] = 6;
      req[2] = 2;
      drive(1'b0);
      n = 0;
      while (!idle() && (n < 300)) begin
         step();
         n++;
      end
      check_val("t3_drain", 32'(idle()), 32'h1);
      check_val("t3_count", 32'(ar_log.size()), 32'd8);
      if (ar_log.size() == 8) begin
         for (int i = 0; i < 8; i++) check_val($sformatf("t3_ord%0d", i), 32'(ar_log[i]), 32'(exp3[i]));
      end

      // m2 owns with ARREADY low for 10 cycles while m0 waits; weight 0 acts as 1.
      do_reset(16'h0000);
      blen   = 3;
      ar_en  = 1'b0;
      req[2] = 1;
      drive(1'b0);
      n = 0;
      while ((grnt_id != 2'd2) && (n < 10)) begin
         step();
         n++;
      end
      check_val("t4_own", 32'(grnt_id), 32'd2);
      req[0] = 1;
      drive(1'b0);
      moved = 1'b0;
      repeat (10) begin
         step();
         if ((grnt_id !== 2'd2) || busy) moved = 1'b1;
      end
      check_val("t4_hold", 32'(moved), 32'h0);
      ar_en = 1'b1;
      drive(1'b0);
      step();
      check_val("t4_hs_busy", 32'(busy), 32'h1);
      check_val("t4_hs_cnt", 32'(ar_log.size()), 32'd1);
      g_cyc = -1;
      first_lst = -1;
      n = 0;
      while (!idle() && (n < 100)) begin
         step();
         n++;
         if (lst_flag && (first_lst < 0)) begin
            first_lst = lst_cyc;
            check_val("t4_beats", 32'(r_beats), 32'd3);
         end
         if (m0_rgrnt && (g_cyc < 0)) g_cyc = cyc;
      end
      check_val("t4_count", 32'(ar_log.size()), 32'd2);
      if (ar_log.size() == 2) begin
         check_val("t4_first", 32'(ar_log[0]), 32'd2);
         check_val("t4_second", 32'(ar_log[1]), 32'd0);
      end
      check_val("t4_m0_gap", 32'(g_cyc - first_lst), 32'd2);

      // Asynchronous reset in the middle of an 8-beat burst.
      do_reset(16'h1111);
      blen   = 8;
      req[1] = 1;
      drive(1'b0);
      n = 0;
      while ((r_beats != 8'd2) && (n < 30)) begin
         step();
         n++;
      end
      check_val("t5_mid_beats", 32'(r_beats), 32'd2);
      check_val("t5_mid_gid", 32'(grnt_id), 32'd1);
      ARESETn = 1'b0;
      #1;
      check_val("t5_rst_grant", 32'(gvec), 32'h1);
      check_val("t5_rst_busy", 32'(busy), 32'h0);
      check_val("t5_rst_beats", 32'(r_beats), 32'h0);
      req[1] = 0;
      remain = 0;
      drive(1'b0);
      @(posedge ACLK);
      #1;
      ARESETn = 1'b1;
      step();
      step();
      check_val("t5_post_grant", 32'(gvec), 32'h1);
      check_val("t5_post_gid", 32'(grnt_id), 32'h0);

`ifdef AXI_ARB_R_TIMEOUT_EN
      // Slave never returns data: timeout after TIMEOUT_CYC cycles in the R phase.
      do_reset(16'h1111);
      blen   = 4;
      rv_en  = 1'b0;
      req[1] = 1;
      drive(1'b0);
      n = 0;
      while (!busy && (n < 10)) begin
         step();
         n++;
      end
      check_val("t6_busy", 32'(busy), 32'h1);
      n = 0;
      while (busy && (n < 40)) begin
         step();
         n++;
      end
      check_val("t6_cycles", 32'(n), 32'd16);
      check_val("t6_err", 32'(timeout_err), 32'h1);
      remain = 0;
      drive(1'b0);
      step();
      check_val("t6_rotate", 32'(grnt_id), 32'd2);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check_val("t6_clr", 32'(timeout_err), 32'h0);
`else
      // Without the timeout the R phase waits indefinitely and no error is raised.
      do_reset(16'h1111);
      blen   = 4;
      rv_en  = 1'b0;
      req[1] = 1;
      drive(1'b0);
      repeat (30) step();
      check_val("t6_stall_busy", 32'(busy), 32'h1);
      check_val("t6_stall_err", 32'(timeout_err), 32'h0);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check_val("t6_stall_gid", 32'(grnt_id), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
